// File: rtl/noc_merge_2to1.sv
// Two-input packet merge with alternating arbitration into a small output FIFO.
// Define NOC_MERGE_STATS_EN to add per-input saturating grant counters.
module noc_merge_2to1 #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
`ifdef NOC_MERGE_STATS_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
`endif
);

  localparam int unsigned PtrW = (DEPTH > 2) ? 2 : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  logic [WIDTH:0]    mem [DEPTH];
  logic [PtrW-1:0]   rdPtrQ, wrPtrQ;
  logic [CntW-1:0]   countQ;
  logic              lastWinnerQ;

  logic              grant0, grant1, notFull;
  logic              push0, push1, push, pop;
  logic [WIDTH:0]    pushEntry;

  function automatic logic [PtrW-1:0] incPtr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // Ready depends only on valids, local state and rst, never on out_ready.
  always_comb begin
    grant0    = in0_valid && (!in1_valid || lastWinnerQ);
    grant1    = in1_valid && (!in0_valid || !lastWinnerQ);
    notFull   = countQ < DepthCnt;
    in0_ready = grant0 && notFull && !rst;
    in1_ready = grant1 && notFull && !rst;
    push0     = in0_valid && in0_ready;
    push1     = in1_valid && in1_ready;
    push      = push0 || push1;
    pushEntry = push1 ? {1'b1, in1_data} : {1'b0, in0_data};
    out_valid = countQ != '0;
    pop       = out_valid && out_ready;
    out_data  = mem[rdPtrQ][WIDTH-1:0];
    out_src   = mem[rdPtrQ][WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtrQ      <= '0;
      wrPtrQ      <= '0;
      countQ      <= '0;
      lastWinnerQ <= 1'b1;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wrPtrQ] <= pushEntry;
        wrPtrQ      <= incPtr(wrPtrQ);
        lastWinnerQ <= push1;
      end
      if (pop) begin
        rdPtrQ <= incPtr(rdPtrQ);
      end
      if (push && !pop) begin
        countQ <= countQ + 1'b1;
      end else if (pop && !push) begin
        countQ <= countQ - 1'b1;
      end
    end
  end

`ifdef NOC_MERGE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (push0 && grant_cnt0 != 16'hFFFF) begin
        grant_cnt0 <= grant_cnt0 + 16'd1;
      end
      if (push1 && grant_cnt1 != 16'hFFFF) begin
        grant_cnt1 <= grant_cnt1 + 16'd1;
      end
    end
  end
`endif

endmodule
